// File: rtl/branch_redirect.sv
// branch_redirect
//   Execute-stage branch resolver. Conditional branches, JAL and JALR are
//   resolved and compared against the fetch-time prediction. A mispredict
//   raises a registered redirect on dataB. The redirect is held until fetch
//   accepts it, and younger wrong-path work is flushed while it waits.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   ex_valid          resolvable instruction present in EX
//   is_branch/jal/jalr instruction class (priority jalr > jal > branch)
//   funct3            branch condition select
//   pc, imm, rs1, rs2 instruction PC, sign-extended immediate, operands
//   pred_taken/target fetch-time prediction
//   fetch_ready       fetch accepts the redirect this cycle
//   dataB             {branch, pc_branch} redirect to fetch PC select
//   flush             kill younger instructions while a redirect is pending
//   misalign          1-cycle pulse: taken target with bit 1 set
//   mispredict_cnt    saturating count of mispredicts since reset
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | resolving EX instructions, no redirect outstanding
// PENDING | redirect on dataB, waiting for fetch_ready; EX is wrong path

module branch_redirect #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             is_branch,
  input  logic             is_jal,
  input  logic             is_jalr,
  input  logic [2:0]       funct3,
  input  logic [63:0]      pc,
  input  logic [63:0]      imm,
  input  logic [63:0]      rs1,
  input  logic [63:0]      rs2,
  input  logic             pred_taken,
  input  logic [63:0]      pred_target,
  input  logic             fetch_ready,
  output logic [64:0]      dataB,
  output logic             flush,
  output logic             misalign,
  output logic [CNT_W-1:0] mispredict_cnt
);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t      state;
  logic        branch_q;
  logic [63:0] pc_branch_q;

  logic        cond;
  logic        taken;
  logic [63:0] target;
  logic        bad_align;
  logic        mispredict;
  logic [63:0] redirect_pc;

  always_comb begin
    cond = 1'b0;
    case (funct3)
      3'b000:  cond = (rs1 == rs2);
      3'b001:  cond = (rs1 != rs2);
      3'b100:  cond = ($signed(rs1) <  $signed(rs2));
      3'b101:  cond = ($signed(rs1) >= $signed(rs2));
      3'b110:  cond = (rs1 <  rs2);
      3'b111:  cond = (rs1 >= rs2);
      default: cond = 1'b0;
    endcase

    if (is_jalr) begin
      target = (rs1 + imm) & ~64'h1;
      taken  = 1'b1;
    end else if (is_jal) begin
      target = pc + imm;
      taken  = 1'b1;
    end else begin
      target = pc + imm;
      taken  = is_branch & cond;
    end

    bad_align   = taken & target[1];
    mispredict  = taken ? (!pred_taken || (pred_target != target)) : pred_taken;
    redirect_pc = taken ? target : (pc + 64'd4);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      branch_q       <= 1'b0;
      pc_branch_q    <= 64'd0;
      misalign       <= 1'b0;
      mispredict_cnt <= '0;
    end else begin
      misalign <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid) begin
            // A misaligned taken target traps instead of redirecting.
            if (bad_align) begin
              misalign <= 1'b1;
            end else if (mispredict) begin
              state       <= PENDING;
              branch_q    <= 1'b1;
              pc_branch_q <= redirect_pc;
              if (mispredict_cnt != '1)
                mispredict_cnt <= mispredict_cnt + CNT_W'(1);
            end
          end
        end
        PENDING: begin
          // EX contents are wrong-path here, including in the accept cycle.
          if (fetch_ready) begin
            state    <= IDLE;
            branch_q <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          branch_q <= 1'b0;
        end
      endcase
    end
  end

  assign dataB = {branch_q, pc_branch_q};
  assign flush = (state == PENDING);

endmodule
